// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: FSM state encodings and synchroniser depth.
// ALU_LOADER_DEBOUNCE_EN (when defined) enables the debounce counter in button_conditioner.
package alu_operand_loader_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        HAVE_A  = 2'b01,
        ILLEGAL = 2'b10,
        READY   = 2'b11
    } state_e;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/alu_operand_loader_button_conditioner.sv
// Button conditioner: 2-flop synchroniser, optional debounce (ALU_LOADER_DEBOUNCE_EN), rising-edge pulse.
// Latency: sync level after 2 edges; debounced level after DB_CYCLES further stable cycles. No backpressure.
module button_conditioner
    import alu_operand_loader_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter bit DEBOUNCE  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level,
    output logic pulse
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  sync_lvl;
    logic                  deb_lvl;
    logic                  prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], btn};
        end
    end

    assign sync_lvl = sync_q[SYNC_DEPTH-1];

`ifdef ALU_LOADER_DEBOUNCE_EN
    if (DEBOUNCE) begin : g_debounce
        localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d;

        // Count cycles the synced level disagrees with the debounced one; any agreement restarts.
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (sync_lvl != lvl_q) begin
                if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                    lvl_d = sync_lvl;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign deb_lvl = lvl_q;
    end else begin : g_no_debounce
        assign deb_lvl = sync_lvl;
    end
`else
    assign deb_lvl = sync_lvl;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= deb_lvl;
        end
    end

    assign level = deb_lvl;
    assign pulse = deb_lvl & ~prev_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures ALU operands a then b from the switches on each load press; clear button empties both.
// Latency: capture on edge 3 (+DB_CYCLES with ALU_LOADER_DEBOUNCE_EN); clear on edge 3. No backpressure.
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             operands_valid,
    output logic [1:0]       state
);

    logic load_level;
    logic load_pulse;
    logic clr_level;
    logic clr_pulse;
    logic clr_act;

    button_conditioner #(
        .DB_CYCLES (DB_CYCLES),
        .DEBOUNCE  (1'b1)
    ) u_load_cond (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_load),
        .level   (load_level),
        .pulse   (load_pulse)
    );

    button_conditioner #(
        .DB_CYCLES (DB_CYCLES),
        .DEBOUNCE  (1'b0)
    ) u_clr_cond (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_clr),
        .level   (clr_level),
        .pulse   (clr_pulse)
    );

    // Clear acts on level; its pulse only ever coincides with a high level, so OR-ing is harmless.
    assign clr_act = clr_level | clr_pulse;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        if (clr_act) begin
            state_d = EMPTY;
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load_pulse) begin
                        a_d     = sw;
                        state_d = HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (load_pulse) begin
                        b_d     = sw;
                        state_d = READY;
                        valid_d = 1'b1;
                    end
                end
                READY: begin
                    if (load_pulse) begin
                        a_d     = sw;
                        state_d = HAVE_A;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign operands_valid = valid_q;
    assign state          = state_q;

endmodule
